// File: rtl/seg_scan_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
// Digit i of the packed display word occupies bits [SEG_W*i +: SEG_W].
package seg_scan_pkg;

  localparam int DIGITS = 6;
  localparam int SEG_W  = 7;
  localparam int WORD_W = DIGITS * SEG_W;
  localparam int IDX_W  = $clog2(DIGITS);

  localparam logic [SEG_W-1:0]  SEG_OFF  = 7'b1111111;
  localparam logic [DIGITS-1:0] AN_OFF   = '1;
  localparam logic [DIGITS-1:0] AN_ONE   = DIGITS'(1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);

  function automatic logic [SEG_W-1:0] digit_slice(
    input logic [WORD_W-1:0] word,
    input logic [IDX_W-1:0]  i
  );
    return word[SEG_W*i +: SEG_W];
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Digit-slot prescaler: counts 0..DIV-1, flags the last cycle of a slot
// (tick) and the leading BLANK cycles of a slot (in_blank).
module scan_prescaler #(
  parameter int DIV   = 50000,
  parameter int BLANK = 2
) (
  input  logic clk,
  input  logic reset,
  output logic tick,
  output logic in_blank
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick     = (cnt_q == CNT_LAST);
  assign in_blank = (cnt_q < CNT_BLANK);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed six-digit seven-segment driver with frame-aligned word swap.
// Optional SEG_GHOST_BLANK_EN darkens the first BLANK cycles of every digit slot.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int BLANK = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] display,
  output logic              ready,
  output logic [SEG_W-1:0]  seg,
  output logic [DIGITS-1:0] an,
  output logic              frame_done
);

  logic tick, in_blank;
  logic wrap, accept;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] active_q, active_d;
  logic [WORD_W-1:0] pending_q, pending_d;
  logic              pend_v_q, pend_v_d;

  scan_prescaler #(
    .DIV  (DIV),
    .BLANK(BLANK)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .in_blank(in_blank)
  );

  assign wrap   = tick && (idx_q == LAST_IDX);
  assign accept = load && !pend_v_q;

  // A load on the wrap cycle only happens with pend_v clear, so it never
  // collides with the swap and lands in pending for the following frame.
  always_comb begin
    idx_d     = idx_q;
    active_d  = active_q;
    pending_d = pending_q;
    pend_v_d  = pend_v_q;
    if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;
    if (wrap && pend_v_q) begin
      active_d = pending_q;
      pend_v_d = 1'b0;
    end
    if (accept) begin
      pending_d = display;
      pend_v_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q     <= '0;
      active_q  <= '0;
      pending_q <= '0;
      pend_v_q  <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pend_v_q  <= pend_v_d;
    end
  end

  assign ready      = !pend_v_q;
  assign frame_done = wrap;

  always_comb begin
    an  = ~(AN_ONE << idx_q);
    seg = ~digit_slice(active_q, idx_q);
`ifdef SEG_GHOST_BLANK_EN
    if (in_blank) begin
      an  = AN_OFF;
      seg = SEG_OFF;
    end
`endif
  end

`ifndef SEG_GHOST_BLANK_EN
  logic unused_in_blank;
  assign unused_in_blank = in_blank;
`endif

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with DIV=4, BLANK=1: time-based reference model
// compared every cycle, plus hand-computed checkpoints.
module tb_seg_scan_driver;
  import seg_scan_pkg::*;

  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME = DIV * DIGITS;

`ifdef SEG_GHOST_BLANK_EN
  localparam bit          GHOST = 1'b1;
  localparam logic [5:0]  R_AN  = 6'b111111;
`else
  localparam bit          GHOST = 1'b0;
  localparam logic [5:0]  R_AN  = 6'b111110;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load = 1'b0;
  logic [WORD_W-1:0] display = '0;
  logic              ready;
  logic [SEG_W-1:0]  seg;
  logic [DIGITS-1:0] an;
  logic              frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // reference model: m_t = cycles since the last reset edge
  int                m_t = 0;
  logic [WORD_W-1:0] m_shown = '0;
  logic [WORD_W-1:0] m_q = '0;
  bit                m_has = 1'b0;

  int         e_slot;
  logic [5:0] e_an;
  logic [6:0] e_seg;

  seg_scan_driver #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .display   (display),
    .ready     (ready),
    .seg       (seg),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got=%h expected=%h", nm, m_t, act, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] pack6(input logic [6:0] d5, input logic [6:0] d4,
                                              input logic [6:0] d3, input logic [6:0] d2,
                                              input logic [6:0] d1, input logic [6:0] d0);
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_t     <= 0;
      m_shown <= '0;
      m_q     <= '0;
      m_has   <= 1'b0;
    end else begin
      m_t <= m_t + 1;
      if ((m_t % FRAME) == FRAME - 1 && m_has) begin
        m_shown <= m_q;
        m_has   <= 1'b0;
      end
      if (load && !m_has) begin
        m_q   <= display;
        m_has <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      e_slot = (m_t / DIV) % DIGITS;
      e_an   = ~(6'b000001 << e_slot);
      e_seg  = ~m_shown[e_slot*SEG_W +: SEG_W];
      if (GHOST && (m_t % DIV) < BLANK) begin
        e_an  = 6'b111111;
        e_seg = 7'b1111111;
      end
      chk("model_an", an, e_an);
      chk("model_seg", seg, e_seg);
      chk("model_frame_done", frame_done, ((m_t % FRAME) == FRAME - 1));
      chk("model_ready", ready, !m_has);
    end
  end

  task automatic goto_t(input int target);
    int guard = 0;
    while (m_t != target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (m_t != target) begin
      n_tests++;
      n_fail++;
      $display("FAIL goto reached t=%0d wanted %0d", m_t, target);
    end
  endtask

  logic [WORD_W-1:0] w1, wa, wb, wc, wd, we;

  initial begin
    w1 = pack6(7'h7F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h06);
    wa = pack6(7'h11, 7'h22, 7'h33, 7'h44, 7'h55, 7'h3F);
    wb = pack6(7'h0F, 7'h0E, 7'h0D, 7'h0C, 7'h0B, 7'h5B);
    wc = pack6(7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h66);
    wd = pack6(7'h7E, 7'h7D, 7'h7B, 7'h77, 7'h6F, 7'h6D);
    we = pack6(7'h2A, 7'h15, 7'h2A, 7'h15, 7'h2A, 7'h7D);

    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_an", an, R_AN);
    chk("reset_seg", seg, 7'b1111111);
    chk("reset_ready", ready, 1'b1);
    chk("reset_frame_done", frame_done, 1'b0);
    reset = 1'b0;

    // idle frame
    for (int c = 0; c < FRAME; c++) begin
      if (c == 5)  chk("idle_an_slot1", an, 6'b111101);
      if (c == 22) chk("idle_fd_22", frame_done, 1'b0);
      if (c == 23) begin
        chk("idle_fd_23", frame_done, 1'b1);
        chk("idle_seg_dark", seg, 7'b1111111);
      end
      @(negedge clk);
    end

    // basic load, visible after the next wrap
    display = w1;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
    display = '1;
    chk("load1_ready_low", ready, 1'b0);
    goto_t(47);
    chk("load1_ready_at_wrap", ready, 1'b0);
    goto_t(49);
    chk("load1_ready_back", ready, 1'b1);
    chk("load1_an_d0", an, 6'b111110);
    chk("load1_seg_d0", seg, 7'h79);
    goto_t(69);
    chk("load1_an_d5", an, 6'b011111);
    chk("load1_seg_d5", seg, 7'h00);

    // second load while busy is dropped
    goto_t(72);
    display = wa;
    load    = 1'b1;
    @(negedge clk);
    display = wb;
    @(negedge clk);
    load = 1'b0;
    chk("busy_ready_low", ready, 1'b0);
    goto_t(97);
    chk("busy_seg_a_d0", seg, 7'h40);
    chk("busy_ready_high", ready, 1'b1);
    display = wc;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("third_load_taken", ready, 1'b0);
    goto_t(101);
    chk("busy_seg_a_d1", seg, 7'h2A);

    // load on the wrap cycle waits a whole frame
    goto_t(143);
    chk("wrap_load_fd", frame_done, 1'b1);
    chk("wrap_load_ready", ready, 1'b1);
    display = wd;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("wrap_load_ready_low", ready, 1'b0);
    goto_t(145);
    chk("wrap_load_old_word", seg, 7'h19);
    goto_t(167);
    chk("wrap_load_pending", ready, 1'b0);
    goto_t(169);
    chk("wrap_load_new_word", seg, 7'h12);
    chk("wrap_load_ready_back", ready, 1'b1);

    // reset mid-frame with a word pending
    goto_t(170);
    display = we;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("pre_reset_pending", ready, 1'b0);
    goto_t(180);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_an", an, R_AN);
    chk("midreset_seg", seg, 7'b1111111);
    chk("midreset_ready", ready, 1'b1);
    goto_t(25);
    chk("midreset_still_dark", seg, 7'b1111111);
    chk("midreset_an_d0", an, 6'b111110);
    goto_t(49);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0d", m_t);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Sequential consumer of the 42-bit packed seven-segment display word that the operation blocks produce: six digits of seven segments each. It time-multiplexes the word onto one shared segment bus plus six digit enables, which is how the board actually drives the display. A load/ready handshake takes new words, and the new word goes live only at a frame boundary, so a refresh never shows a partial update.

## Interface
- DIGITS, 6, number of digits scanned
- SEG_W, 7, segments per digit
- DIV, 50000, clock cycles per digit slot (≥2)
- BLANK, 2, leading dark cycles per slot when blanking is compiled in (< DIV)
- clk  in  1  system clock, single clock domain
- reset  in  1  synchronous, active-high
- load  in  1  request to capture `display`
- display  in  DIGITS*SEG_W (42)  packed word, digit i = display[7i+6:7i], segment bit 1 = lit
- ready  out  1  high when a load will be accepted
- seg  out  SEG_W  shared segment bus, active-low, bit order as in `display`
- an  out  DIGITS  digit enables, active-low, an[i] selects digit i
- frame_done  out  1  one-cycle pulse at each frame wrap

## Operation
- Registers:
  - prescaler `cnt` counts 0..DIV-1.
  - digit index `idx` counts 0..DIGITS-1.
  - `active` is the word being shown.
  - `pending` is the next word, with its flag `pend_v`.
- tick = (cnt == DIV-1).
  - On tick, cnt wraps to 0 and idx advances.
  - When idx == DIGITS-1 on a tick, idx wraps to 0 and frame_done pulses that cycle.
- Handshake: `ready` = !pend_v.
  - A load with ready=1 captures `display` into pending and sets pend_v.
  - A load with ready=0 is ignored, with no error flag.
- Swap: on the frame-wrap cycle, if pend_v=1, then active ← pending and pend_v clears. ready returns to 1 on the next cycle.
- A load accepted on the frame-wrap cycle itself goes into pending. It is swapped at the following wrap, not the current one.
- Outputs are combinational from the registers:
  - an = ~(1 << idx)
  - seg = ~active[7·idx+6 : 7·idx]
- Reset values:
  - cnt = 0, idx = 0.
  - active = 0 and pending = 0.
  - pend_v = 0, so ready = 1.
  - an = 6'b111110, seg = 7'b1111111 (all dark).
  - frame_done = 0.
- Reset mid-frame aborts the scan and discards any pending word. The display is dark until a load completes and a full frame wrap has passed.

## Timing
- Digit slot = DIV cycles. Frame = DIGITS·DIV cycles.
- The first frame_done after reset occurs at cycle DIGITS·DIV − 1, counting the first cycle after reset deassertion as cycle 0.
- Load-to-visible latency: from the accepting edge to the next frame wrap, then visible starting at digit 0. Worst case is DIGITS·DIV cycles.
- ready falls the cycle after acceptance and rises the cycle after the swap.
- `display` is sampled only on the accepting edge. It may change at any other time.

## Configuration
- SEG_GHOST_BLANK_EN
- Defined:
  - For cnt < BLANK in every slot, an is forced to all-ones and seg to all-ones, which suppresses ghosting between digits.
  - All counters, the handshake and frame_done are unchanged.
- Undefined: an and seg follow the Operation rules on every cycle.

## Structure
- Package `seg_scan_pkg` holds:
  - the DIGITS and SEG_W constants;
  - SEG_OFF = 7'b1111111 and AN_OFF;
  - a digit-slice function that returns the SEG_W bits of digit i from the packed word.
- Sub-module `scan_prescaler` is the natural split:
  - it holds cnt and produces `tick` and the `in_blank` flag (cnt < BLANK);
  - the top level holds idx, active, pending and the handshake.

## Test plan
Run all scenarios with DIV=4, BLANK=1.

- Reset, then hold idle for 24 cycles.
  - an cycles through 111110, 111101, … 011111, each for 4 cycles.
  - seg stays 1111111 throughout.
  - frame_done pulses at cycle 23.
- Load with digit 0 = 7'h06 and digit 5 = 7'h7F, all other digits 0.
  - After the next wrap, seg = 7'h79 while an = 111110, and seg = 7'h00 while an = 011111.
  - ready is low from the acceptance edge until one cycle after the wrap.
- Load word A, then load word B while ready=0.
  - B is ignored, and A is displayed after the wrap.
  - A third load after ready returns to 1 is accepted.
- Load asserted exactly on a frame_done cycle.
  - The frame that follows still shows the old word.
  - The new word appears after the second wrap.
- Assert reset for 1 cycle mid-frame while pend_v=1.
  - Outputs return to their reset values on the next cycle and ready = 1.
  - The pending word is never displayed.
- With SEG_GHOST_BLANK_EN defined:
  - the first cycle of every slot has an = 111111 and seg = 1111111;
  - frame_done timing is identical to the undefined build.
